clk_div_ctrl: RTL and testbench
===============================

# clk_div_ctrl

Run-time programmable clock-divider controller. It produces a divided clock from `clk` and accepts new divide ratios through a valid/ready handshake. A new ratio takes effect only at a falling edge of the divided clock, so no truncated or runt high phase is ever produced. Enable and disable are glitch-free. It sits between the register/config interface and any logic that consumes the divided clock or its edge strobes.

## Interface
- `CW`, 16: counter and ratio width in bits.
- `DEF_DIV`, 4: divide ratio after reset. Must be even, at least 2, and at most 2^CW−2.

Ports (name, direction, width, meaning):
- `clk`, in, 1: clock.
- `rstn`, in, 1: reset. Synchronous, active-low.
- `en`, in, 1: run request, level-sensitive.
- `cfg_valid`, in, 1: a new ratio is offered.
- `cfg_div`, in, CW: offered divide ratio.
- `cfg_ready`, out, 1: controller can accept a ratio this cycle.
- `cfg_err`, out, 1: one-cycle pulse; the accepted ratio was illegal and was discarded.
- `div_cur`, out, CW: ratio currently in effect.
- `clk_o`, out, 1: divided clock, registered.
- `rise_o`, out, 1: one-cycle pulse in the first cycle `clk_o` reads 1.
- `fall_o`, out, 1: one-cycle pulse in the first cycle `clk_o` reads 0 after being high.
- `busy`, out, 1: state is not STOP.

## Operation
- Half period is `half = div_cur >> 1`. Counter `cnt` is CW bits wide.
- In RUN and PEND, `cnt` counts 0..half−1. When `cnt == half−1`, `cnt` returns to 0 and `clk_o` toggles.
- A ratio is legal if it is even and at least 2. Illegal ratios include 0, 1 and all odd values.
- A transfer occurs when `cfg_valid && cfg_ready`.

State machine:
- **STOP**
  - `clk_o` = 0 and `cnt` = 0.
  - `cfg_ready` = 1. A legal accepted ratio is written to `div_cur` on the next edge.
  - `en` = 1 → RUN.
- **RUN**
  - `cfg_ready` = 1. A legal accepted ratio is latched into `div_nxt` → PEND.
  - `en` = 0 → DRAIN flag set, stay in RUN.
  - If the DRAIN flag is set: at the next falling toggle, or immediately if `clk_o` is already 0 → STOP.
- **PEND**
  - `cfg_ready` = 0.
  - At the falling toggle, `div_cur` ← `div_nxt` and the new half period applies to that low phase → RUN.
  - If `clk_o` is 0 at acceptance, the current low phase completes with the old ratio, then high uses the old ratio, and the swap happens at the following falling toggle.
- An illegal ratio is still handshaked (accepted). `cfg_err` pulses the next cycle, and `div_cur`, `div_nxt` and the state are unchanged.
- **Simultaneous `en` = 0 and pending ratio:** the swap happens at the same falling edge that enters STOP, so `div_cur` holds the new ratio in STOP.
- **`en` re-asserted while draining:** the DRAIN flag clears and the controller stays in RUN with no disturbance.
- **Reset mid-operation:**
  - `clk_o`, `cnt`, `rise_o`, `fall_o`, `cfg_err` and `busy` = 0.
  - `div_cur` = `DEF_DIV`; any pending ratio is discarded.
  - `cfg_ready` = 1 and state = STOP, all on the next edge.

## Timing
- Reset values: `clk_o` = 0, `rise_o` = 0, `fall_o` = 0, `cfg_err` = 0, `busy` = 0, `cfg_ready` = 1, `div_cur` = `DEF_DIV`.
- `en` sampled high at edge T: `busy` = 1 from T+1. The first `clk_o` = 1 appears `half` cycles after the first RUN cycle.
- Steady state: `clk_o` is high for `half` cycles and low for `half` cycles.
- `rise_o` and `fall_o` are registered alongside `clk_o`, so they are coincident with the new `clk_o` level.
- `cfg_err` is asserted in the cycle after the transfer.
- In STOP, `div_cur` updates in the cycle after the transfer.
- `div_cur` changes in the same cycle `clk_o` reads 0 following the swap edge.
- Divide ratio 2: `clk_o` toggles every cycle.

## Structure
- Package `clk_div_pkg` holds:
  - the state enum `{STOP, RUN, PEND}`;
  - the default `CW`;
  - a legal-ratio check function (even and ≥2).
- One natural sub-module, `clk_div_core`. It contains the half-period counter and toggle register, with inputs `run` and `half` and outputs `clk_o`, `rise_o`, `fall_o` and `toggle_fall`.
- `clk_div_ctrl` contains the FSM, the handshake, the DRAIN flag and the `div_cur`/`div_nxt` registers.

## Test plan
- **Reset then run:** reset, then `en` = 1 with `DEF_DIV` = 4 → `clk_o` runs 2 cycles high, 2 cycles low; `rise_o` pulses every 4 cycles; `busy` = 1.
- **Ratio change while high:** offer `cfg_div` = 6 one cycle into a high phase → the high phase finishes at 2 cycles; the following low and high phases are 3 cycles each; `div_cur` = 6 at the fall; `cfg_ready` = 0 until then.
- **Illegal ratios:** offer `cfg_div` = 5, then `cfg_div` = 0 → `cfg_err` pulses once for each; `div_cur` stays 4; `clk_o` period is unchanged.
- **Disable mid-high:** with `div_cur` = 8, drop `en` one cycle into a high phase → the high phase lasts a full 4 cycles, then `clk_o` = 0, `fall_o` pulses, `busy` = 0 in that cycle, and `clk_o` stays 0.
- **Disable with pending change:** drop `en` and offer `cfg_div` = 2 in the same cycle → STOP is reached at the fall with `div_cur` = 2. Re-enabling gives `clk_o` toggling every cycle.
- **Reset mid-PEND:** pulse `rstn` low with `div_nxt` = 10 pending → `clk_o` = 0, `div_cur` = 4, `cfg_ready` = 1 and state STOP the next cycle; after re-enable the period is 4.

Source files
------------

// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
package clk_div_pkg;

  localparam int unsigned CW_DEF = 16;

  typedef enum logic [1:0] {
    STOP,
    RUN,
    PEND
  } state_t;

  // Even and non-zero is the same as even and at least 2.
  function automatic logic div_legal(input logic lsb, input logic nonzero);
    return !lsb && nonzero;
  endfunction

endpackage

// File: rtl/clk_div_core.sv
// Half-period counter and toggle register producing the divided clock and its edge strobes.
module clk_div_core
  import clk_div_pkg::*;
#(
  parameter int unsigned CW = CW_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          run,
  input  logic [CW-1:0] half,
  output logic          clk_o,
  output logic          rise_o,
  output logic          fall_o,
  output logic          toggle_fall
);

  logic [CW-1:0] cnt;
  logic          wrap;

  assign wrap        = run && (cnt == half - CW'(1));
  assign toggle_fall = wrap && clk_o;

  always_ff @(posedge clk) begin
    if (!rstn || !run) begin
      cnt    <= '0;
      clk_o  <= 1'b0;
      rise_o <= 1'b0;
      fall_o <= 1'b0;
    end else begin
      rise_o <= wrap && !clk_o;
      fall_o <= wrap && clk_o;
      if (wrap) begin
        cnt   <= '0;
        clk_o <= !clk_o;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/clk_div_ctrl.sv
// Clock-divider controller: ratio handshake, run/drain FSM, ratio swap at falling edges.
module clk_div_ctrl
  import clk_div_pkg::*;
#(
  parameter int unsigned CW      = CW_DEF,
  parameter int unsigned DEF_DIV = 4
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          en,
  input  logic          cfg_valid,
  input  logic [CW-1:0] cfg_div,
  output logic          cfg_ready,
  output logic          cfg_err,
  output logic [CW-1:0] div_cur,
  output logic          clk_o,
  output logic          rise_o,
  output logic          fall_o,
  output logic          busy
);

  state_t        state_q, state_d;
  logic [CW-1:0] div_cur_q, div_cur_d;
  logic [CW-1:0] div_nxt_q, div_nxt_d;
  logic [CW-1:0] half;
  logic          drain_q;
  logic          xfer, legal, stop_req, stop_now, toggle_fall;

  assign cfg_ready = (state_q != PEND);
  assign busy      = (state_q != STOP);
  assign div_cur   = div_cur_q;
  assign half      = div_cur_q >> 1;
  assign xfer      = cfg_valid && cfg_ready;
  assign legal     = div_legal(cfg_div[0], |cfg_div);
  // Re-asserting en cancels a drain without touching the waveform.
  assign stop_req  = drain_q && !en;
  assign stop_now  = stop_req && (toggle_fall || !clk_o);

  clk_div_core #(
    .CW(CW)
  ) u_core (
    .clk         (clk),
    .rstn        (rstn),
    .run         (busy),
    .half        (half),
    .clk_o       (clk_o),
    .rise_o      (rise_o),
    .fall_o      (fall_o),
    .toggle_fall (toggle_fall)
  );

  always_comb begin
    state_d   = state_q;
    div_cur_d = div_cur_q;
    div_nxt_d = div_nxt_q;
    unique case (state_q)
      STOP: begin
        if (xfer && legal) div_cur_d = cfg_div;
        if (en) state_d = RUN;
      end
      RUN: begin
        // A ratio arriving on the stopping edge can be applied directly.
        if (stop_now) begin
          state_d = STOP;
          if (xfer && legal) div_cur_d = cfg_div;
        end else if (xfer && legal) begin
          div_nxt_d = cfg_div;
          state_d   = PEND;
        end
      end
      PEND: begin
        if (toggle_fall) begin
          div_cur_d = div_nxt_q;
          state_d   = stop_req ? STOP : RUN;
        end
      end
      default: state_d = STOP;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q   <= STOP;
      div_cur_q <= CW'(DEF_DIV);
      div_nxt_q <= '0;
      drain_q   <= 1'b0;
      cfg_err   <= 1'b0;
    end else begin
      state_q   <= state_d;
      div_cur_q <= div_cur_d;
      div_nxt_q <= div_nxt_d;
      drain_q   <= busy && !en;
      cfg_err   <= xfer && !legal;
    end
  end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed self-checking bench for clk_div_ctrl.
module tb_clk_div_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        en;
  logic        cfg_valid;
  logic [15:0] cfg_div;
  logic        cfg_ready;
  logic        cfg_err;
  logic [15:0] div_cur;
  logic        clk_o;
  logic        rise_o;
  logic        fall_o;
  logic        busy;

  int total = 0;
  int bad   = 0;

  clk_div_ctrl #(
    .CW     (16),
    .DEF_DIV(4)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .en        (en),
    .cfg_valid (cfg_valid),
    .cfg_div   (cfg_div),
    .cfg_ready (cfg_ready),
    .cfg_err   (cfg_err),
    .div_cur   (div_cur),
    .clk_o     (clk_o),
    .rise_o    (rise_o),
    .fall_o    (fall_o),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rise(output int n);
    n = 0;
    for (int i = 0; i < 64; i++) begin
      step();
      n++;
      if (rise_o === 1'b1) break;
    end
  endtask

  task automatic measure_high(output int n);
    n = 1;
    for (int i = 0; i < 64; i++) begin
      step();
      if (clk_o === 1'b1) n++;
      else break;
    end
  endtask

  task automatic measure_low(output int n);
    n = 1;
    for (int i = 0; i < 64; i++) begin
      step();
      if (clk_o === 1'b0) n++;
      else break;
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    step(); step();
    total++; if (clk_o !== 1'b0) begin bad++; $display("FAIL reset_clk_o got=%0b exp=0", clk_o); end
    total++; if (rise_o !== 1'b0) begin bad++; $display("FAIL reset_rise got=%0b exp=0", rise_o); end
    total++; if (fall_o !== 1'b0) begin bad++; $display("FAIL reset_fall got=%0b exp=0", fall_o); end
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL reset_err got=%0b exp=0", cfg_err); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", busy); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b exp=1", cfg_ready); end
    total++; if (div_cur !== 16'd4) begin bad++; $display("FAIL reset_div got=%0d exp=4", div_cur); end
    rstn = 1'b1;
    step();
  endtask

  task automatic test_run();
    int n;
    en = 1'b1;
    step();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL run_busy got=%0b exp=1", busy); end
    total++; if (clk_o !== 1'b0) begin bad++; $display("FAIL run_first got=%0b exp=0", clk_o); end
    wait_rise(n);
    total++; if (n != 2) begin bad++; $display("FAIL run_first_rise got=%0d exp=2", n); end
    measure_high(n);
    total++; if (n != 2) begin bad++; $display("FAIL run_high got=%0d exp=2", n); end
    total++; if (fall_o !== 1'b1) begin bad++; $display("FAIL run_fall got=%0b exp=1", fall_o); end
    measure_low(n);
    total++; if (n != 2) begin bad++; $display("FAIL run_low got=%0d exp=2", n); end
    total++; if (rise_o !== 1'b1) begin bad++; $display("FAIL run_rise got=%0b exp=1", rise_o); end
  endtask

  task automatic test_illegal();
    int n;
    cfg_valid = 1'b1; cfg_div = 16'd5;
    step();
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL err_odd got=%0b exp=1", cfg_err); end
    cfg_div = 16'd0;
    step();
    total++; if (cfg_err !== 1'b1) begin bad++; $display("FAIL err_zero got=%0b exp=1", cfg_err); end
    cfg_valid = 1'b0;
    step();
    total++; if (cfg_err !== 1'b0) begin bad++; $display("FAIL err_clear got=%0b exp=0", cfg_err); end
    total++; if (div_cur !== 16'd4) begin bad++; $display("FAIL err_div got=%0d exp=4", div_cur); end
    wait_rise(n);
    total++; if (n != 1) begin bad++; $display("FAIL err_phase got=%0d exp=1", n); end
    measure_high(n);
    total++; if (n != 2) begin bad++; $display("FAIL err_high got=%0d exp=2", n); end
    measure_low(n);
    total++; if (n != 2) begin bad++; $display("FAIL err_low got=%0d exp=2", n); end
  endtask

  task automatic test_ratio_change();
    int n;
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL chg_ready_pre got=%0b exp=1", cfg_ready); end
    cfg_valid = 1'b1; cfg_div = 16'd6;
    step();
    cfg_valid = 1'b0;
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL chg_ready_pend got=%0b exp=0", cfg_ready); end
    total++; if (div_cur !== 16'd4) begin bad++; $display("FAIL chg_div_pend got=%0d exp=4", div_cur); end
    total++; if (clk_o !== 1'b1) begin bad++; $display("FAIL chg_still_high got=%0b exp=1", clk_o); end
    step();
    total++; if (fall_o !== 1'b1) begin bad++; $display("FAIL chg_fall got=%0b exp=1", fall_o); end
    total++; if (div_cur !== 16'd6) begin bad++; $display("FAIL chg_div_swap got=%0d exp=6", div_cur); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL chg_ready_post got=%0b exp=1", cfg_ready); end
    measure_low(n);
    total++; if (n != 3) begin bad++; $display("FAIL chg_low got=%0d exp=3", n); end
    measure_high(n);
    total++; if (n != 3) begin bad++; $display("FAIL chg_high got=%0d exp=3", n); end
  endtask

  task automatic test_change_while_low();
    int n;
    cfg_valid = 1'b1; cfg_div = 16'd8;
    step();
    cfg_valid = 1'b0;
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL low_ready got=%0b exp=0", cfg_ready); end
    wait_rise(n);
    total++; if (n != 2) begin bad++; $display("FAIL low_old_low got=%0d exp=2", n); end
    measure_high(n);
    total++; if (n != 3) begin bad++; $display("FAIL low_old_high got=%0d exp=3", n); end
    total++; if (div_cur !== 16'd8) begin bad++; $display("FAIL low_div got=%0d exp=8", div_cur); end
    measure_low(n);
    total++; if (n != 4) begin bad++; $display("FAIL low_new_low got=%0d exp=4", n); end
  endtask

  task automatic test_disable_mid_high();
    int n;
    en = 1'b0;
    measure_high(n);
    total++; if (n != 4) begin bad++; $display("FAIL dis_high got=%0d exp=4", n); end
    total++; if (fall_o !== 1'b1) begin bad++; $display("FAIL dis_fall got=%0b exp=1", fall_o); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL dis_busy got=%0b exp=0", busy); end
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (clk_o !== 1'b0) begin bad++; $display("FAIL dis_hold got=%0b exp=0", clk_o); end
    end
  endtask

  task automatic test_disable_pending();
    int n;
    en = 1'b1;
    wait_rise(n);
    total++; if (n != 5) begin bad++; $display("FAIL pdis_start got=%0d exp=5", n); end
    en = 1'b0; cfg_valid = 1'b1; cfg_div = 16'd2;
    step();
    cfg_valid = 1'b0;
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL pdis_ready got=%0b exp=0", cfg_ready); end
    measure_high(n);
    total++; if (n != 3) begin bad++; $display("FAIL pdis_high got=%0d exp=3", n); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL pdis_busy got=%0b exp=0", busy); end
    total++; if (div_cur !== 16'd2) begin bad++; $display("FAIL pdis_div got=%0d exp=2", div_cur); end
    en = 1'b1;
    step();
    total++; if (clk_o !== 1'b0) begin bad++; $display("FAIL div2_first got=%0b exp=0", clk_o); end
    for (int i = 0; i < 4; i++) begin
      logic exp_lvl;
      exp_lvl = (i % 2 == 0);
      step();
      total++; if (clk_o !== exp_lvl) begin bad++; $display("FAIL div2_toggle got=%0b exp=%0b", clk_o, exp_lvl); end
    end
  endtask

  task automatic test_reset_mid_pend();
    int n;
    cfg_valid = 1'b1; cfg_div = 16'd10;
    step();
    cfg_valid = 1'b0;
    total++; if (cfg_ready !== 1'b0) begin bad++; $display("FAIL rpend_pend got=%0b exp=0", cfg_ready); end
    rstn = 1'b0; en = 1'b0;
    step();
    total++; if (clk_o !== 1'b0) begin bad++; $display("FAIL rpend_clk got=%0b exp=0", clk_o); end
    total++; if (div_cur !== 16'd4) begin bad++; $display("FAIL rpend_div got=%0d exp=4", div_cur); end
    total++; if (cfg_ready !== 1'b1) begin bad++; $display("FAIL rpend_ready got=%0b exp=1", cfg_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rpend_busy got=%0b exp=0", busy); end
    total++; if (fall_o !== 1'b0) begin bad++; $display("FAIL rpend_fall got=%0b exp=0", fall_o); end
    rstn = 1'b1;
    step();
    total++; if (div_cur !== 16'd4) begin bad++; $display("FAIL rpend_discard got=%0d exp=4", div_cur); end
    en = 1'b1;
    wait_rise(n);
    total++; if (n != 3) begin bad++; $display("FAIL rpend_start got=%0d exp=3", n); end
    measure_high(n);
    total++; if (n != 2) begin bad++; $display("FAIL rpend_high got=%0d exp=2", n); end
    measure_low(n);
    total++; if (n != 2) begin bad++; $display("FAIL rpend_low got=%0d exp=2", n); end
  endtask

  task automatic test_reenable_drain();
    int n;
    en = 1'b0;
    step();
    en = 1'b1;
    step();
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL redrain_busy got=%0b exp=1", busy); end
    total++; if (fall_o !== 1'b1) begin bad++; $display("FAIL redrain_fall got=%0b exp=1", fall_o); end
    measure_low(n);
    total++; if (n != 2) begin bad++; $display("FAIL redrain_low got=%0d exp=2", n); end
    total++; if (rise_o !== 1'b1) begin bad++; $display("FAIL redrain_rise got=%0b exp=1", rise_o); end
  endtask

  initial begin
    test_reset();
    test_run();
    test_illegal();
    test_ratio_change();
    test_change_while_low();
    test_disable_mid_high();
    test_disable_pending();
    test_reset_mid_pend();
    test_reenable_drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
